spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per SPI word.
REQ-002 SHALL have port clk  in  1  single system clock; all logic on posedge clk.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port mode  in  2  SPI mode; mode[1]=CPOL, mode[0]=CPHA.
REQ-005 SHALL have port sclk  in  1  SPI clock from master, asynchronous to clk.
REQ-006 SHALL have port cs_n  in  1  slave select from master, active-low, asynchronous.
REQ-007 SHALL have port mosi  in  1  serial data from master, asynchronous.
REQ-008 SHALL have port miso  out  1  serial data to master.
REQ-009 SHALL have port miso_oe  out  1  miso output enable, high while selected.
REQ-010 SHALL have port tx_data  in  WIDTH  next word to transmit.
REQ-011 SHALL have port tx_wr  in  1  write strobe for tx_data into the holding register.
REQ-012 SHALL have port tx_ready  out  1  holding register empty, tx_wr accepted.
REQ-013 SHALL have port rx_data  out  WIDTH  last complete received word.
REQ-014 SHALL have port rx_valid  out  1  one-cycle pulse, rx_data updated.
REQ-015 SHALL have port tx_underrun  out  1  one-cycle pulse, word loaded while holding register empty.
REQ-016 SHALL have port busy  out  1  high while selected (state ACTIVE).

Function
REQ-017 SHALL pass sclk, cs_n, mosi through 2-flop synchronizers plus one history flop for edge detection; the edge-detect latency is 3 clk cycles.
REQ-018 SHALL require sclk high and low phases of at least 4 clk cycles each; behaviour at faster sclk is undefined.
REQ-019 SHALL have states IDLE and ACTIVE: IDLE->ACTIVE on synchronized cs_n fall; ACTIVE->IDLE on synchronized cs_n rise.
REQ-020 SHALL latch mode on IDLE->ACTIVE; changes to mode while ACTIVE are ignored.
REQ-021 SHALL define the leading edge as an sclk transition away from its CPOL idle level and the trailing edge as the return to it.
REQ-022 SHALL, for CPHA=0, sample mosi on leading edges and shift miso on trailing edges; for CPHA=1, shift on leading edges and sample on trailing edges.
REQ-023 SHALL transfer MSB first; miso equals the tx shift register MSB while ACTIVE and 0 in IDLE; miso_oe equals busy.
REQ-024 SHALL keep a bit counter of width clog2(WIDTH), cleared on entry to ACTIVE and incremented per sample edge; it wraps from WIDTH-1 to 0.
REQ-025 SHALL, on the sample edge bringing the counter to 0, load rx_data with the full word (new bit in LSB) and pulse rx_valid in the same cycle the shift completes.
REQ-026 SHALL perform word-load events as follows: for CPHA=0, on IDLE->ACTIVE and on each trailing edge with counter=0 after a completed word; for CPHA=1, on each leading edge with counter=0. All other shift edges shift left.
REQ-027 SHALL, on a word-load event with the holding register full, copy it into the shift register and set tx_ready=1 in the next cycle.
REQ-028 SHALL, on a word-load event with the holding register empty, load all zeros and pulse tx_underrun.
REQ-029 SHALL accept tx_wr only when tx_ready=1, capturing tx_data and clearing tx_ready; tx_wr while tx_ready=0 is dropped with no state change.
REQ-030 SHALL, when tx_wr coincides with a word-load event and the holding register is empty, signal underrun for the current word and keep the written value for the next word.
REQ-031 SHALL, on deselect mid-word, discard the partial word (no rx_valid), clear the counter and shift registers, and leave the holding register unchanged.
REQ-032 SHALL ignore sclk edges while IDLE.
REQ-033 SHALL let rx_data hold its value until the next completed word; there is no receive back-pressure.

Reset
REQ-034 SHALL, with rst high at posedge clk, enter IDLE with miso=0, miso_oe=0, busy=0, rx_data=0, rx_valid=0, tx_underrun=0, tx_ready=1, holding register empty, counter 0, and synchronizer flops at idle levels (cs_n=1, sclk=0, mosi=0).
REQ-035 SHALL let rst take priority over all other inputs, including mid-transfer, with no rx_valid generated.

Verification
REQ-036 SHALL cover mode 0: tx_wr 0xA5, master sends 0x3C -> miso carries 0xA5 MSB first, rx_data=0x3C, one rx_valid pulse, tx_ready back to 1.
REQ-037 SHALL cover modes 1, 2 and 3 with the same exchange -> identical data results on the correct edges per REQ-022.
REQ-038 SHALL cover a 2-word burst with cs_n held low, holding register refilled with 0x11 after the first load -> second word on miso is 0x11 and two rx_valid pulses occur.
REQ-039 SHALL cover selection with holding register empty -> miso all zeros, one tx_underrun pulse, receive unaffected.
REQ-040 SHALL cover deselect after 5 bits -> no rx_valid, rx_data unchanged, next frame received correctly from bit 0.
REQ-041 SHALL cover tx_wr while tx_ready=0, and rst asserted mid-word -> write dropped; after reset all outputs at REQ-034 values.

Source files
------------

// File: rtl/spi_slave_if.sv
// SPI bus pins between an external master and the spi_slave block.
interface spi_slave_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport slave  (input sclk, cs_n, mosi, output miso, miso_oe);
  modport master (output sclk, cs_n, mosi, input miso, miso_oe);
endinterface

// File: rtl/spi_slave.sv
// SPI slave, all four modes, oversampled on clk: sclk/cs_n/mosi are synchronized
// and edge-detected, so sclk phases must span several clk cycles.
module spi_slave #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  spi_slave_if.slave       spi,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_wr,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // [0],[1] synchronize, [2] is the history flop for edge detection
  logic [2:0] sclk_sr, cs_sr;
  logic [1:0] mosi_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sr <= '0;
      cs_sr   <= '1;
      mosi_sr <= '0;
    end else begin
      sclk_sr <= {sclk_sr[1:0], spi.sclk};
      cs_sr   <= {cs_sr[1:0], spi.cs_n};
      mosi_sr <= {mosi_sr[0], spi.mosi};
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
  assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
  assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
  assign cs_fall   = ~cs_sr[1] & cs_sr[2];
  assign cs_rise   = cs_sr[1] & ~cs_sr[2];
  assign mosi_s    = mosi_sr[1];

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [WIDTH-1:0] tx_sh;
  logic [WIDTH-2:0] rx_sh;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full;
  logic [CW-1:0]    cnt_q;
  logic             word_done_q;
  logic             cpol_q, cpha_q;

  logic enter, leave, act, lead_edge, trail_edge;
  logic sample_ev, shift_ev, load_ev;

  assign enter      = (state_q == IDLE) && cs_fall;
  assign leave      = (state_q == ACTIVE) && cs_rise;
  assign act        = (state_q == ACTIVE) && !cs_rise;
  assign lead_edge  = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge = cpol_q ? sclk_rise : sclk_fall;
  assign sample_ev  = act && (cpha_q ? trail_edge : lead_edge);
  assign shift_ev   = act && (cpha_q ? lead_edge : trail_edge);
  // CPHA=0 needs the MSB on the wire before the first leading edge, so it loads on select;
  // CPHA=1 loads on the leading edge that starts each word.
  assign load_ev    = (enter && !mode[0]) ||
                      (shift_ev && (cnt_q == '0) && (cpha_q || word_done_q));
  assign rx_next    = {rx_sh, mosi_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sh       <= '0;
      rx_sh       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      cnt_q       <= '0;
      word_done_q <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      if (leave) begin
        // partial word is dropped; the holding register is left alone
        tx_sh       <= '0;
        rx_sh       <= '0;
        cnt_q       <= '0;
        word_done_q <= 1'b0;
      end else begin
        if (enter) begin
          cnt_q       <= '0;
          word_done_q <= 1'b0;
          cpol_q      <= mode[1];
          cpha_q      <= mode[0];
        end
        if (sample_ev) begin
          rx_sh <= rx_next[WIDTH-2:0];
          if (cnt_q == LAST) begin
            cnt_q       <= '0;
            rx_data     <= rx_next;
            rx_valid    <= 1'b1;
            word_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        if (load_ev) begin
          tx_sh       <= hold_full ? hold_q : '0;
          tx_underrun <= ~hold_full;
          word_done_q <= 1'b0;
        end else if (shift_ev) begin
          tx_sh <= tx_sh << 1;
        end
      end
    end
  end

  // A write coinciding with an empty-register load still lands, for the next word.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else if (load_ev && hold_full) begin
      hold_full <= 1'b0;
    end else if (tx_wr && !hold_full) begin
      hold_q    <= tx_data;
      hold_full <= 1'b1;
    end
  end

  assign tx_ready = ~hold_full;

  logic miso_c, miso_oe_c;

  always_comb begin
    busy      = (state_q == ACTIVE);
    miso_oe_c = busy;
    miso_c    = busy ? tx_sh[WIDTH-1] : 1'b0;
  end

  assign spi.miso    = miso_c;
  assign spi.miso_oe = miso_oe_c;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-level SPI master task drives frames, received words
// are scored against a queue of expected words.
module tb_spi_slave;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       busy;

  spi_slave_if spi();

  spi_slave #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .spi(spi.slave),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int rxv_cnt = 0;
  int und_cnt = 0;
  int rd_idx = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] obs_rx[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      obs_rx.push_back(rx_data);
      rxv_cnt++;
    end
    if (tx_underrun) und_cnt++;
  end

  task automatic sb_check(input string name);
    logic [7:0] e;
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      vectors++;
      if (rd_idx >= obs_rx.size()) begin
        miscompares++;
        $display("FAIL %s rx_missing got=none expected=%h", name, e);
      end else begin
        if (obs_rx[rd_idx] !== e) begin
          miscompares++;
          $display("FAIL %s rx_data got=%h expected=%h", name, obs_rx[rd_idx], e);
        end
        rd_idx++;
      end
    end
    vectors++;
    if (obs_rx.size() != rd_idx) begin
      miscompares++;
      $display("FAIL %s rx_extra got=%0d words expected=%0d", name, obs_rx.size(), rd_idx);
      rd_idx = obs_rx.size();
    end
  endtask

  task automatic tx_write(input logic [7:0] v);
    tx_data = v;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr   = 1'b0;
    @(negedge clk);
  endtask

  task automatic spi_frame(input logic [1:0] m, input int nbits, input logic [15:0] mo,
                           input bit refill, input logic [7:0] rv, input bit keep_cs,
                           output logic [15:0] mi);
    logic cpol, cpha;
    cpol = m[1];
    cpha = m[0];
    mi = '0;
    mode = m;
    spi.sclk = cpol;
    spi.cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
    if (!cpha) spi.mosi = mo[nbits-1];
    spi.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    if (refill) begin
      tx_data = rv;
      tx_wr   = 1'b1;
      @(negedge clk);
      tx_wr   = 1'b0;
    end
    for (int i = 0; i < nbits; i++) begin
      spi.sclk = ~cpol;
      if (!cpha) mi = {mi[14:0], spi.miso};
      else       spi.mosi = mo[nbits-1-i];
      repeat (HALF) @(negedge clk);
      if (cpha) mi = {mi[14:0], spi.miso};
      spi.sclk = cpol;
      if (!cpha && i < nbits - 1) spi.mosi = mo[nbits-2-i];
      repeat (HALF) @(negedge clk);
    end
    if (!keep_cs) begin
      spi.cs_n = 1'b1;
      repeat (12) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    vectors++;
    if ({spi.miso, spi.miso_oe, busy, rx_valid, tx_underrun, tx_ready} !== 6'b000001) begin
      miscompares++;
      $display("FAIL reset_flags got=%b expected=000001",
               {spi.miso, spi.miso_oe, busy, rx_valid, tx_underrun, tx_ready});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (rx_data !== 8'h00 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release got rx=%h busy=%b rdy=%b expected rx=00 busy=0 rdy=1",
               rx_data, busy, tx_ready);
    end
  endtask

  task automatic test_mode(input logic [1:0] m);
    logic [15:0] mi;
    int rxv0, und0, und_exp;
    tx_write(8'hA5);
    vectors++;
    if (tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mode%0d tx_ready_after_wr got=%b expected=0", m, tx_ready);
    end
    rxv0 = rxv_cnt;
    und0 = und_cnt;
    // CPHA=0 reloads on the trailing edge closing the word, which underruns when empty
    und_exp = m[0] ? 0 : 1;
    exp_rx.push_back(8'h3C);
    spi_frame(m, 8, 16'h003C, 1'b0, 8'h00, 1'b0, mi);
    vectors++;
    if (mi[7:0] !== 8'hA5) begin
      miscompares++;
      $display("FAIL mode%0d miso got=%h expected=a5", m, mi[7:0]);
    end
    vectors++;
    if (rxv_cnt - rxv0 != 1 || tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mode%0d rxv_rdy got=%0d/%b expected=1/1", m, rxv_cnt - rxv0, tx_ready);
    end
    vectors++;
    if (und_cnt - und0 != und_exp) begin
      miscompares++;
      $display("FAIL mode%0d underruns got=%0d expected=%0d", m, und_cnt - und0, und_exp);
    end
    sb_check($sformatf("mode%0d", m));
  endtask

  task automatic test_back_to_back();
    logic [15:0] mi;
    int rxv0, und0;
    tx_write(8'hA5);
    rxv0 = rxv_cnt;
    und0 = und_cnt;
    exp_rx.push_back(8'h3C);
    exp_rx.push_back(8'h96);
    spi_frame(2'd0, 16, 16'h3C96, 1'b1, 8'h11, 1'b0, mi);
    vectors++;
    if (mi !== 16'hA511) begin
      miscompares++;
      $display("FAIL burst miso got=%h expected=a511", mi);
    end
    vectors++;
    if (rxv_cnt - rxv0 != 2 || und_cnt - und0 != 1) begin
      miscompares++;
      $display("FAIL burst pulses got rxv=%0d und=%0d expected rxv=2 und=1",
               rxv_cnt - rxv0, und_cnt - und0);
    end
    sb_check("burst");
  endtask

  task automatic test_underrun();
    logic [15:0] mi;
    int und0;
    und0 = und_cnt;
    exp_rx.push_back(8'h5A);
    spi_frame(2'd1, 8, 16'h005A, 1'b0, 8'h00, 1'b0, mi);
    vectors++;
    if (mi[7:0] !== 8'h00) begin
      miscompares++;
      $display("FAIL underrun miso got=%h expected=00", mi[7:0]);
    end
    vectors++;
    if (und_cnt - und0 != 1) begin
      miscompares++;
      $display("FAIL underrun pulses got=%0d expected=1", und_cnt - und0);
    end
    sb_check("underrun");
  endtask

  task automatic test_abort();
    logic [15:0] mi;
    int rxv0;
    tx_write(8'hC3);
    rxv0 = rxv_cnt;
    spi_frame(2'd0, 5, 16'h0015, 1'b0, 8'h00, 1'b0, mi);
    vectors++;
    if (mi[4:0] !== 5'b11000) begin
      miscompares++;
      $display("FAIL abort miso_bits got=%b expected=11000", mi[4:0]);
    end
    vectors++;
    if (rxv_cnt != rxv0 || rx_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL abort rx got rxv=%0d data=%h expected rxv=0 data=5a", rxv_cnt - rxv0, rx_data);
    end
    sb_check("abort");
    exp_rx.push_back(8'hE7);
    spi_frame(2'd0, 8, 16'h00E7, 1'b0, 8'h00, 1'b0, mi);
    vectors++;
    if (mi[7:0] !== 8'h00) begin
      miscompares++;
      $display("FAIL abort_next miso got=%h expected=00", mi[7:0]);
    end
    sb_check("abort_next");
  endtask

  task automatic test_drop_and_reset();
    logic [15:0] mi;
    tx_write(8'h77);
    tx_data = 8'h88;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr   = 1'b0;
    @(negedge clk);
    vectors++;
    if (tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL drop tx_ready got=%b expected=0", tx_ready);
    end
    exp_rx.push_back(8'h42);
    spi_frame(2'd1, 8, 16'h0042, 1'b0, 8'h00, 1'b0, mi);
    vectors++;
    if (mi[7:0] !== 8'h77) begin
      miscompares++;
      $display("FAIL drop miso got=%h expected=77", mi[7:0]);
    end
    sb_check("drop");
    tx_write(8'h99);
    spi_frame(2'd0, 4, 16'h000B, 1'b0, 8'h00, 1'b1, mi);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({spi.miso, spi.miso_oe, busy, rx_valid, tx_underrun, tx_ready} !== 6'b000001 ||
        rx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset flags got=%b rx=%h expected=000001 rx=00",
               {spi.miso, spi.miso_oe, busy, rx_valid, tx_underrun, tx_ready}, rx_data);
    end
    spi.cs_n = 1'b1;
    spi.sclk = 1'b0;
    spi.mosi = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || tx_ready !== 1'b1 || rx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL postreset got busy=%b rdy=%b rx=%h expected 0/1/00", busy, tx_ready, rx_data);
    end
    sb_check("reset");
  endtask

  initial begin
    rst      = 1'b1;
    mode     = 2'd0;
    tx_data  = '0;
    tx_wr    = 1'b0;
    spi.sclk = 1'b0;
    spi.cs_n = 1'b1;
    spi.mosi = 1'b0;
    test_reset();
    for (int m = 0; m < 4; m++) test_mode(2'(m));
    test_back_to_back();
    test_underrun();
    test_abort();
    test_drop_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
